// File: rtl/bcd_seg_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter / 7-segment driver.
// Latency: none (pure constants and functions).
// Backpressure: not applicable.
package bcd_seg_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bits needed to hold 0..n-1 (at least 1)
    function automatic int width_of(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Any non-decimal digit is treated as 9
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] bcd2seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            default: s = SEG_9;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_multidigit_seg_ctrl_if.sv
// Front-panel / display bundle between the panel logic and the BCD counter block.
// Latency: none (wires only).
// Backpressure: none; inputs are levels/pulses, outputs are registered in the block.
interface bcd_multidigit_seg_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  we;
    logic                  btn;
    logic                  btn_sel;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic [4*DIGITS-1:0]   value;
    logic                  wrap;

    modport master (
        output en, we, btn, btn_sel,
        input  seg, an, value, wrap
    );

    modport slave (
        input  en, we, btn, btn_sel,
        output seg, an, value, wrap
    );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchroniser plus stability counter, press = accepted 1->0.
// Latency: 2 sync cycles + DEBOUNCE_CYC stable samples before level/press_pulse move.
// Backpressure: none; press_pulse is a single-cycle event per accepted press.
module btn_debounce
    import bcd_seg_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press_pulse
);
    localparam int              DB_W     = width_of(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts it
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset reports the button as released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level       = level_q;
    assign press_pulse = press_q;
endmodule

// File: rtl/bcd_multidigit_seg_ctrl.sv
// N-digit BCD counter with in-place digit editor and multiplexed 7-segment scan driver.
// Latency: value/wrap update 1 cycle after en or a debounced edit event; seg/an registered together.
// Backpressure: none; en is a single-cycle tick, button events outside EDIT are dropped.
module bcd_multidigit_seg_ctrl
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_DIV    = 1 << 22,
    parameter int DEBOUNCE_CYC = 1 << 16
) (
    input  logic                     clk,
    input  logic                     rst,
    bcd_multidigit_seg_ctrl_if.slave bus
);
    localparam int                 CUR_W      = width_of(DIGITS);
    localparam int                 SCAN_W     = width_of(SCAN_DIV);
    localparam int                 BLINK_W    = width_of(BLINK_DIV);
    localparam logic [CUR_W-1:0]   CUR_LAST   = CUR_W'(DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [CUR_W-1:0]    cur_q, cur_d;
    logic [CUR_W-1:0]    idx_q, idx_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_on_q, blink_on_d;
    logic                we_q, we_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          show_dig;

    logic                btn_level, btn_press;
    logic                sel_level, sel_press;
    logic                unused_levels;
    logic                run_inc, edit_inc, edit_sel;
    logic [DIGITS:0]     carry;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (bus.btn),
        .level       (btn_level),
        .press_pulse (btn_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sel (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (bus.btn_sel),
        .level       (sel_level),
        .press_pulse (sel_press)
    );

    // Debounced levels are kept on the debouncer for probing; only the press events drive logic here
    assign unused_levels = btn_level ^ sel_level;

    assign run_inc  = ~bus.we & bus.en;
    assign edit_inc = bus.we & btn_press;
    assign edit_sel = bus.we & sel_press;

    // Ripple carry chain in RUN; in EDIT only the cursor digit steps, with no carry out
    assign carry[0] = run_inc;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] dig;
        logic       hit;
        assign dig          = bcd_sat(value_q[4*i +: 4]);
        assign hit          = edit_inc && (cur_q == CUR_W'(i));
        assign carry[i+1]   = carry[i] && (dig == 4'd9);
        assign value_d[4*i +: 4] = (carry[i] || hit) ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
    end

    // Next-state for cursor, blink, scan and the registered display outputs
    always_comb begin
        cur_d = cur_q;
        if (edit_sel) begin
            cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
        end

        // carry out of the top digit only happens on a RUN tick at all-9s
        wrap_d = carry[DIGITS];
        we_d   = bus.we;

        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (bus.we && !we_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (bus.we) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == CUR_LAST) ? '0 : idx_q + 1'b1;
        end

        // Display is built from next-state so an/seg always describe the same digit and value
        show_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == CUR_W'(i)) show_dig = value_d[4*i +: 4];
        end
        an_d  = ~(DIGITS'(1) << idx_d);
        seg_d = {1'b0, bcd2seg(show_dig)};
        if (bus.we && (idx_d == cur_d)) begin
            seg_d = blink_on_d ? {1'b1, bcd2seg(show_dig)} : {1'b0, SEG_BLANK};
        end
    end

    // All state and outputs registered; reset shows digit 0 as "0"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q     <= '0;
            cur_q       <= '0;
            idx_q       <= '0;
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            we_q        <= 1'b0;
            wrap_q      <= 1'b0;
            an_q        <= ~DIGITS'(1);
            seg_q       <= {1'b0, SEG_0};
        end else begin
            value_q     <= value_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            we_q        <= we_d;
            wrap_q      <= wrap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.value = value_q;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
endmodule
